// File: rtl/data_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_ctrl: RV32 load/store unit bridging the core to a word bus  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module data_mem_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_busy,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam int                c_CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

  localparam logic [2:0] c_F3_B  = 3'b000;
  localparam logic [2:0] c_F3_H  = 3'b001;
  localparam logic [2:0] c_F3_W  = 3'b010;
  localparam logic [2:0] c_F3_BU = 3'b100;
  localparam logic [2:0] c_F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_we;
  logic [2:0]         r_funct3;
  logic [1:0]         r_offset;
  logic [c_CNT_W-1:0] r_cnt;

  logic               w_is_byte;
  logic               w_is_half;
  logic               w_is_word;
  logic               w_legal_code;
  logic               w_misaligned;
  logic               w_req_ok;
  logic [3:0]         w_wstrb;
  logic [31:0]        w_wdata;
  logic [7:0]         w_lane_byte;
  logic [15:0]        w_lane_half;
  logic [31:0]        w_load;
  logic [c_CNT_W-1:0] w_cnt_next;

  // Request decode, evaluated on the raw request inputs in IDLE.
  always_comb begin
    w_is_byte    = (req_funct3[1:0] == 2'b00);
    w_is_half    = (req_funct3[1:0] == 2'b01);
    w_is_word    = (req_funct3[1:0] == 2'b10);
    w_legal_code = 1'b0;
    if (req_we) begin
      w_legal_code = (req_funct3 == c_F3_B) || (req_funct3 == c_F3_H) ||
                     (req_funct3 == c_F3_W);
    end else begin
      w_legal_code = (req_funct3 == c_F3_B)  || (req_funct3 == c_F3_H)  ||
                     (req_funct3 == c_F3_W)  || (req_funct3 == c_F3_BU) ||
                     (req_funct3 == c_F3_HU);
    end
    w_misaligned = (w_is_half && req_addr[0]) || (w_is_word && (req_addr[1:0] != 2'b00));
    w_req_ok     = w_legal_code && !w_misaligned;
  end

  // Byte-lane strobes and replicated store data.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = req_wdata;
    if (req_we) begin
      if (w_is_byte) begin
        w_wstrb = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end else if (w_is_half) begin
        w_wstrb = 4'b0011 << req_addr[1:0];
        w_wdata = {2{req_wdata[15:0]}};
      end else begin
        w_wstrb = 4'b1111;
        w_wdata = req_wdata;
      end
    end
  end

  // Load lane extraction from the returned bus word.
  always_comb begin
    w_lane_byte = bus_rdata[7:0];
    case (r_offset)
      2'd0:    w_lane_byte = bus_rdata[7:0];
      2'd1:    w_lane_byte = bus_rdata[15:8];
      2'd2:    w_lane_byte = bus_rdata[23:16];
      default: w_lane_byte = bus_rdata[31:24];
    endcase
    w_lane_half = r_offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    w_load      = bus_rdata;
    case (r_funct3)
      c_F3_B:  w_load = {{24{w_lane_byte[7]}}, w_lane_byte};
      c_F3_H:  w_load = {{16{w_lane_half[15]}}, w_lane_half};
      c_F3_BU: w_load = {24'd0, w_lane_byte};
      c_F3_HU: w_load = {16'd0, w_lane_half};
      default: w_load = bus_rdata;
    endcase
  end

  assign w_cnt_next = r_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_funct3  <= 3'b000;
      r_offset  <= 2'b00;
      r_cnt     <= '0;
      mem_busy  <= 1'b0;
      rdata     <= 32'd0;
      fault     <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_wstrb <= 4'b0000;
      bus_wdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_offset <= req_addr[1:0];
            mem_busy <= 1'b1;
            if (w_req_ok) begin
              fault     <= 1'b0;
              bus_req   <= 1'b1;
              bus_we    <= req_we;
              bus_addr  <= {req_addr[31:2], 2'b00};
              bus_wstrb <= w_wstrb;
              bus_wdata <= w_wdata;
              r_cnt     <= '0;
              r_state   <= S_ACCESS;
            end else begin
              // Busy stays up through the DONE cycle so a rejected request
              // hands back to the core on the same cycle as a fastest access.
              fault   <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_ACCESS: begin
          if (bus_ready) begin
            if (!r_we) begin
              rdata <= w_load;
            end
            bus_req  <= 1'b0;
            mem_busy <= 1'b0;
            r_state  <= S_DONE;
          end else if (w_cnt_next == c_TIMEOUT) begin
            bus_req  <= 1'b0;
            mem_busy <= 1'b0;
            fault    <= 1'b1;
            r_cnt    <= w_cnt_next;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        S_DONE: begin
          mem_busy <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          bus_req  <= 1'b0;
          mem_busy <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl (TIMEOUT=4)     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        mem_busy;
  logic [31:0] rdata;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  data_mem_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_busy(mem_busy), .rdata(rdata), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          busy_len;
    int          req_len;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        we;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: ready after rsp_delay request cycles unless hung.
  int          rsp_delay = 0;
  bit          rsp_hang = 1'b0;
  logic [31:0] rsp_word = 32'd0;
  int          rsp_cnt = 0;
  always @(negedge clk) begin
    if (bus_req) begin
      bus_ready = (!rsp_hang && rsp_cnt == rsp_delay);
      bus_rdata = bus_ready ? rsp_word : 32'h5A5A_5A5A;
      rsp_cnt++;
    end else begin
      bus_ready = 1'b0;
      bus_rdata = 32'h5A5A_5A5A;
      rsp_cnt   = 0;
    end
  end

  // Monitor: one comparison set per completed access (falling mem_busy).
  int          m_busy = 0;
  int          m_req = 0;
  logic        m_prev_busy = 1'b0;
  logic        m_stable = 1'b1;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [3:0]  m_wstrb = 4'd0;
  logic        m_we = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      m_busy = 0; m_req = 0; m_prev_busy = 1'b0; m_stable = 1'b1;
    end else begin
      if (bus_req) begin
        if (m_req == 0) begin
          m_addr = bus_addr; m_wdata = bus_wdata; m_wstrb = bus_wstrb; m_we = bus_we;
        end else if (bus_addr !== m_addr || bus_wdata !== m_wdata ||
                     bus_wstrb !== m_wstrb || bus_we !== m_we) begin
          m_stable = 1'b0;
        end
        m_req++;
      end
      if (mem_busy) begin
        m_busy++;
      end else if (m_prev_busy) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_completion: got rdata %h with no expected entry", rdata);
        end else begin
          exp_t e;
          e = q.pop_front();
          check32("rdata", rdata, e.rdata);
          check32("fault", {31'd0, fault}, {31'd0, e.fault});
          check32("busy_cycles", m_busy, e.busy_len);
          check32("bus_req_cycles", m_req, e.req_len);
          if (e.req_len > 0) begin
            check32("bus_addr", m_addr, e.addr);
            check32("bus_wstrb", {28'd0, m_wstrb}, {28'd0, e.wstrb});
            check32("bus_wdata", m_wdata, e.wdata);
            check32("bus_we", {31'd0, m_we}, {31'd0, e.we});
            check32("bus_stable", {31'd0, m_stable}, 32'd1);
          end
        end
        m_busy = 0; m_req = 0; m_stable = 1'b1;
      end
      m_prev_busy = mem_busy;
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] word, input int delay,
                       input bit hang, input bit extra, input logic [31:0] e_rdata,
                       input logic e_fault, input int e_busy, input int e_req,
                       input logic [31:0] e_addr, input logic [3:0] e_wstrb,
                       input logic [31:0] e_wdata);
    exp_t e;
    e.rdata = e_rdata; e.fault = e_fault; e.busy_len = e_busy; e.req_len = e_req;
    e.addr = e_addr; e.wstrb = e_wstrb; e.wdata = e_wdata; e.we = we;
    @(posedge clk); #1;
    rsp_delay = delay; rsp_hang = hang; rsp_word = word;
    q.push_back(e);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    if (extra) begin
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'hFFFF_FFF0; req_wdata = 32'h0BAD_0BAD;
    end else begin
      req_valid = 1'b0;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL completion_wait: got %0d pending entries expected 0", q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check32("rst_mem_busy", {31'd0, mem_busy}, 32'd0);
    check32("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check32("rst_bus_we", {31'd0, bus_we}, 32'd0);
    check32("rst_fault", {31'd0, fault}, 32'd0);
    check32("rst_rdata", rdata, 32'd0);
    check32("rst_bus_addr", bus_addr, 32'd0);
    check32("rst_bus_wstrb", {28'd0, bus_wstrb}, 32'd0);
    check32("rst_bus_wdata", bus_wdata, 32'd0);
    @(posedge clk); #2 reset = 1'b1;
    repeat (2) @(posedge clk);

    //     we   f3      addr          wdata         bus word     d  h  x  rdata         flt busy req  addr          strb     wdata
    issue(1'b0, 3'b010, 32'h0000_0100, 32'd0,        32'hDEAD_BEEF, 0, 0, 0, 32'hDEAD_BEEF, 0, 1, 1, 32'h0000_0100, 4'b0000, 32'd0);
    issue(1'b0, 3'b000, 32'h0000_0103, 32'd0,        32'h8000_0000, 0, 0, 0, 32'hFFFF_FF80, 0, 1, 1, 32'h0000_0100, 4'b0000, 32'd0);
    issue(1'b0, 3'b100, 32'h0000_0103, 32'd0,        32'h8000_0000, 0, 0, 0, 32'h0000_0080, 0, 1, 1, 32'h0000_0100, 4'b0000, 32'd0);
    issue(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'hFFFF_FFFF, 1, 0, 0, 32'h0000_0080, 0, 2, 2, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD);
    issue(1'b0, 3'b010, 32'h0000_0101, 32'd0,        32'hFFFF_FFFF, 0, 0, 0, 32'h0000_0080, 1, 1, 0, 32'd0,         4'b0000, 32'd0);
    issue(1'b0, 3'b001, 32'h0000_0102, 32'd0,        32'h8001_7FFF, 2, 0, 1, 32'hFFFF_8001, 0, 3, 3, 32'h0000_0100, 4'b0000, 32'd0);
    issue(1'b0, 3'b101, 32'h0000_0100, 32'd0,        32'h8001_F234, 0, 0, 0, 32'h0000_F234, 0, 1, 1, 32'h0000_0100, 4'b0000, 32'd0);
    issue(1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 0, 0, 32'h0000_F234, 0, 1, 1, 32'h0000_0000, 4'b0010, 32'hA5A5_A5A5);
    issue(1'b1, 3'b010, 32'h0000_000C, 32'hCAFE_F00D, 32'hFFFF_FFFF, 3, 0, 0, 32'h0000_F234, 0, 4, 4, 32'h0000_000C, 4'b1111, 32'hCAFE_F00D);
    issue(1'b0, 3'b010, 32'h0000_0300, 32'd0,        32'hFFFF_FFFF, 0, 1, 0, 32'h0000_F234, 1, 4, 4, 32'h0000_0300, 4'b0000, 32'd0);
    issue(1'b0, 3'b011, 32'h0000_0100, 32'd0,        32'hFFFF_FFFF, 0, 0, 0, 32'h0000_F234, 1, 1, 0, 32'd0,         4'b0000, 32'd0);
    issue(1'b1, 3'b100, 32'h0000_0100, 32'h1111_1111, 32'hFFFF_FFFF, 0, 0, 0, 32'h0000_F234, 1, 1, 0, 32'd0,         4'b0000, 32'd0);
    issue(1'b1, 3'b001, 32'h0000_0203, 32'h2222_2222, 32'hFFFF_FFFF, 0, 0, 0, 32'h0000_F234, 1, 1, 0, 32'd0,         4'b0000, 32'd0);
    issue(1'b0, 3'b001, 32'h0000_0001, 32'd0,        32'hFFFF_FFFF, 0, 0, 0, 32'h0000_F234, 1, 1, 0, 32'd0,         4'b0000, 32'd0);
    issue(1'b0, 3'b000, 32'h0000_0001, 32'd0,        32'h0000_7F00, 0, 0, 0, 32'h0000_007F, 0, 1, 1, 32'h0000_0000, 4'b0000, 32'd0);

    // Abandon a hung load with an asynchronous reset pulse.
    @(posedge clk); #1;
    rsp_hang = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0400;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'd0;
    check32("access_bus_req", {31'd0, bus_req}, 32'd1);
    check32("access_mem_busy", {31'd0, mem_busy}, 32'd1);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    check32("abort_bus_req", {31'd0, bus_req}, 32'd0);
    check32("abort_mem_busy", {31'd0, mem_busy}, 32'd0);
    check32("abort_rdata", rdata, 32'd0);
    check32("abort_fault", {31'd0, fault}, 32'd0);
    @(posedge clk); #2 reset = 1'b1; rsp_hang = 1'b0;
    repeat (2) @(posedge clk);

    issue(1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344, 32'hFFFF_FFFF, 0, 0, 0, 32'h0000_0000, 0, 1, 1, 32'h0000_0010, 4'b1111, 32'h1122_3344);
    issue(1'b0, 3'b010, 32'h0000_0104, 32'd0,        32'h0123_4567, 0, 0, 0, 32'h0123_4567, 0, 1, 1, 32'h0000_0104, 4'b0000, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
